change_arbiter: RTL and testbench

- Generates the 2-bit `change` select for the three-way control-source mux (interupt, rt_sw, soft_dump, sw_acq1, sw_acq2).
- Arbitrates between three pulse-sequence engines that request ownership of the control outputs.
- Sequences every source switch through a guard interval, so the mux output settles before the new owner drives it.
- Waits for the old owner's `busy` to fall before releasing, so a sequence is never cut mid-flight.

---
 rtl/change_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_change_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/change_arbiter.sv
// ---------------------------------------------------------------------------
// change_arbiter
//
// Produces the 2-bit `change` select for the shared control-source mux and
// arbitrates ownership of that mux between three pulse-sequence engines.
// Every hand-over is sequenced:
//
//   PARK -> GUARD -> GRANT -> DRAIN -> PARK
//
// `change` moves first and the grant follows GUARD_CYC cycles later, so the
// mux output has settled before the new owner drives it.  On release, `change`
// is held until the old owner's busy flag falls, so a running sequence is
// never cut off.  PARK always lasts at least one cycle, which means `change`
// passes through 2'b11 on every switch, including a switch back to the same
// engine.
//
// Optional feature (compile-time macro WATCHDOG_EN): a watchdog limits how
// long one owner may hold the mux.  It forces a release WDOG_CYCLES+1 edges
// after grant assertion, ignoring req and busy.  Without the macro no counter
// is built and wdog_trip is tied low.
//
// Ports:
//   clk_sys     in   1  system clock, rising edge
//   rst         in   1  synchronous active-high reset
//   req         in   3  level ownership request, bit i = engine i
//   busy        in   3  engine i still mid-sequence (delays the release)
//   change      out  2  mux select: 0/1/2 = engine, 3 = park
//   gnt         out  3  one-hot grant
//   sel_active  out  1  high whenever the arbiter is not in PARK
//   wdog_trip   out  1  one-cycle pulse on a watchdog-forced release
//
// All outputs are registered; there is no combinational path from req or
// busy to any output.
// ---------------------------------------------------------------------------
module change_arbiter #(
    parameter int GUARD_CYC   = 4,
    parameter int WDOG_CYCLES = 65535,
    parameter int WDOG_W      = 16
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [2:0] busy,
    output logic [1:0] change,
    output logic [2:0] gnt,
    output logic       sel_active,
    output logic       wdog_trip
);

    // Parameter sanity checks, evaluated at elaboration.
    if (GUARD_CYC < 1) begin : g_bad_guard
        $error("change_arbiter: GUARD_CYC must be at least 1");
    end
    if (64'(WDOG_CYCLES) >= (64'd1 << WDOG_W)) begin : g_bad_wdog
        $error("change_arbiter: WDOG_CYCLES does not fit in WDOG_W bits");
    end

    localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

    typedef enum logic [1:0] {PARK, GUARD, GRANT, DRAIN} state_t;

    state_t         state_reg, state_next;
    logic [1:0]     change_reg, change_next;
    logic [2:0]     gnt_reg, gnt_next;
    logic           sel_active_reg, sel_active_next;
    logic [1:0]     owner_reg, owner_next;
    logic [1:0]     last_owner_reg, last_owner_next;
    logic [GW-1:0]  guard_cnt_reg, guard_cnt_next;

    // Round-robin candidates: cand[0] is the engine right after last_owner,
    // cand[2] is last_owner itself (lowest priority).
    logic [1:0] cand [3];
    logic [2:0] cand_req;
    logic [1:0] winner;

    for (genvar gi = 0; gi < 3; gi++) begin : g_rr
        logic [2:0] sum;
        assign sum          = {1'b0, last_owner_reg} + 3'(gi + 1);
        assign cand[gi]     = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
        assign cand_req[gi] = req[cand[gi]];
    end

    always_comb begin
        winner = cand[2];
        if (cand_req[1]) winner = cand[1];
        if (cand_req[0]) winner = cand[0];
    end

`ifdef WATCHDOG_EN
    logic [WDOG_W-1:0] wdog_cnt_reg, wdog_cnt_next;
    logic              wdog_trip_reg, wdog_trip_next;
`endif

    always_comb begin
        state_next      = state_reg;
        change_next     = change_reg;
        gnt_next        = gnt_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        guard_cnt_next  = guard_cnt_reg;

        case (state_reg)
            PARK: begin
                if (|req) begin
                    owner_next     = winner;
                    change_next    = winner;
                    guard_cnt_next = GW'(GUARD_CYC - 1);
                    state_next     = GUARD;
                end
            end
            GUARD: begin
                // A request withdrawn during the guard still has to drain,
                // since `change` already points at that engine.
                if (!req[owner_reg]) begin
                    state_next = DRAIN;
                end else if (guard_cnt_reg == '0) begin
                    gnt_next   = 3'b001 << owner_reg;
                    state_next = GRANT;
                end else begin
                    guard_cnt_next = guard_cnt_reg - GW'(1);
                end
            end
            GRANT: begin
                if (!req[owner_reg]) begin
                    gnt_next   = 3'b000;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!busy[owner_reg]) begin
                    change_next     = 2'b11;
                    last_owner_next = owner_reg;
                    state_next      = PARK;
                end
            end
            default: state_next = PARK;
        endcase

`ifdef WATCHDOG_EN
        // Counter is zero outside GRANT/DRAIN, so it restarts from zero on
        // the edge that asserts the grant (or enters DRAIN from GUARD).
        wdog_trip_next = 1'b0;
        wdog_cnt_next  = '0;
        if (state_reg == GRANT || state_reg == DRAIN) begin
            wdog_cnt_next = wdog_cnt_reg + WDOG_W'(1);
            if (wdog_cnt_reg == WDOG_W'(WDOG_CYCLES)) begin
                gnt_next        = 3'b000;
                change_next     = 2'b11;
                last_owner_next = owner_reg;
                wdog_trip_next  = 1'b1;
                state_next      = PARK;
                wdog_cnt_next   = '0;
            end
        end
`endif

        sel_active_next = (state_next != PARK);
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_reg      <= PARK;
            change_reg     <= 2'b11;
            gnt_reg        <= 3'b000;
            sel_active_reg <= 1'b0;
            owner_reg      <= 2'd0;
            last_owner_reg <= 2'd2;
            guard_cnt_reg  <= '0;
`ifdef WATCHDOG_EN
            wdog_cnt_reg   <= '0;
            wdog_trip_reg  <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            change_reg     <= change_next;
            gnt_reg        <= gnt_next;
            sel_active_reg <= sel_active_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            guard_cnt_reg  <= guard_cnt_next;
`ifdef WATCHDOG_EN
            wdog_cnt_reg   <= wdog_cnt_next;
            wdog_trip_reg  <= wdog_trip_next;
`endif
        end
    end

    assign change     = change_reg;
    assign gnt        = gnt_reg;
    assign sel_active = sel_active_reg;
`ifdef WATCHDOG_EN
    assign wdog_trip  = wdog_trip_reg;
`else
    assign wdog_trip  = 1'b0;
`endif

endmodule

// File: tb/tb_change_arbiter.sv
// ---------------------------------------------------------------------------
// tb_change_arbiter
//
// Directed scenarios with hand-derived expectations, followed by randomized
// req/busy traffic checked every cycle against a behavioural reference model
// that tracks ownership phases with absolute cycle deadlines.
// ---------------------------------------------------------------------------
module tb_change_arbiter;

    localparam int GUARD = 4;
    localparam int WDOG  = 20;
`ifdef WATCHDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    logic       clk_sys = 1'b0;
    logic       rst     = 1'b1;
    logic [2:0] req     = 3'b000;
    logic [2:0] busy    = 3'b000;
    logic [1:0] change;
    logic [2:0] gnt;
    logic       sel_active;
    logic       wdog_trip;

    change_arbiter #(
        .GUARD_CYC  (GUARD),
        .WDOG_CYCLES(WDOG),
        .WDOG_W     (16)
    ) dut (
        .clk_sys   (clk_sys),
        .rst       (rst),
        .req       (req),
        .busy      (busy),
        .change    (change),
        .gnt       (gnt),
        .sel_active(sel_active),
        .wdog_trip (wdog_trip)
    );

    always #5 clk_sys = ~clk_sys;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 settling, 2 owned, 3 draining
    int m_phase, m_owner, m_last, m_due, m_wd_start;
    int e_change, e_gnt, e_sel, e_trip;

    task automatic model_step();
        bit found;
        cyc++;
        e_trip = 0;
        if (rst) begin
            m_phase = 0; m_owner = 0; m_last = 2;
            e_change = 3; e_gnt = 0;
        end else begin
            case (m_phase)
                0: if (req != 3'b000) begin
                    found = 1'b0;
                    for (int k = 1; k <= 3; k++) begin
                        int c;
                        c = (m_last + k) % 3;
                        if (!found && req[c]) begin
                            found   = 1'b1;
                            m_owner = c;
                        end
                    end
                    e_change = m_owner;
                    m_due    = cyc + GUARD;
                    m_phase  = 1;
                end
                1: if (!req[m_owner]) begin
                    m_phase    = 3;
                    m_wd_start = cyc;
                end else if (cyc == m_due) begin
                    e_gnt      = 1 << m_owner;
                    m_phase    = 2;
                    m_wd_start = cyc;
                    $display("grant engine %0d at cycle %0d", m_owner, cyc);
                end
                default: begin
                    if (WD_ON && cyc == m_wd_start + WDOG + 1) begin
                        e_gnt = 0; e_change = 3; m_last = m_owner;
                        e_trip = 1; m_phase = 0;
                    end else if (m_phase == 2 && !req[m_owner]) begin
                        e_gnt = 0; m_phase = 3;
                    end else if (m_phase == 3 && !busy[m_owner]) begin
                        e_change = 3; m_last = m_owner; m_phase = 0;
                    end
                end
            endcase
        end
        e_sel = (m_phase != 0) ? 1 : 0;
    endtask

    // One clock: drive, edge, update model, sample #1 later, compare.
    task automatic step(input logic [2:0] rq, input logic [2:0] bs);
        req  = rq;
        busy = bs;
        @(posedge clk_sys);
        model_step();
        #1;
        check("change", int'(change), e_change);
        check("gnt", int'(gnt), e_gnt);
        check("sel_active", int'(sel_active), e_sel);
        check("wdog_trip", int'(wdog_trip), e_trip);
        if (gnt != 3'b000) check("park_code_with_gnt", int'(change == 2'b11), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(3'b000, 3'b000);
        step(3'b000, 3'b000);
        rst = 1'b0;
    endtask

    task automatic wait_grant(input int e, input logic [2:0] rq, input logic [2:0] bs);
        for (int i = 0; i < 20 && gnt == 3'b000; i++) step(rq, bs);
        check("grant_engine", int'(gnt), 1 << e);
    endtask

    int order [4] = '{0, 1, 2, 0};

    initial begin
        logic [2:0] r, b;

        // Reset held with all requests high
        for (int i = 0; i < 3; i++) begin
            step(3'b111, 3'b000);
            check("rst_change", int'(change), 3);
            check("rst_gnt", int'(gnt), 0);
            check("rst_sel", int'(sel_active), 0);
        end
        rst = 1'b0;
        step(3'b111, 3'b000);
        check("first_winner_change", int'(change), 0);

        // Single request latency, guard length and release timing
        do_reset();
        step(3'b001, 3'b000);
        check("lat_change", int'(change), 0);
        for (int i = 0; i < GUARD - 1; i++) begin
            step(3'b001, 3'b000);
            check("lat_gnt_guard", int'(gnt), 0);
        end
        step(3'b001, 3'b000);
        check("lat_gnt", int'(gnt), 1);
        step(3'b001, 3'b000);
        step(3'b000, 3'b000);
        check("rel_gnt", int'(gnt), 0);
        check("rel_change_held", int'(change), 0);
        step(3'b000, 3'b000);
        check("rel_change_park", int'(change), 3);

        // Round-robin rotation with all engines requesting
        do_reset();
        for (int j = 0; j < 4; j++) begin
            wait_grant(order[j], 3'b111, 3'b000);
            for (int i = 0; i < 3; i++) begin
                step(3'b111, 3'b000);
                check("rr_hold", int'(gnt), 1 << order[j]);
            end
            step(3'(7 & ~(1 << order[j])), 3'b000);
            check("rr_rel_gnt", int'(gnt), 0);
            step(3'b111, 3'b000);
            check("rr_park", int'(change), 3);
        end

        // Release delayed by busy
        do_reset();
        wait_grant(1, 3'b010, 3'b000);
        step(3'b000, 3'b010);
        check("busy_gnt", int'(gnt), 0);
        check("busy_change", int'(change), 1);
        for (int i = 0; i < 9; i++) begin
            step(3'b000, 3'b010);
            check("busy_hold", int'(change), 1);
        end
        step(3'b000, 3'b000);
        check("busy_park", int'(change), 3);

        // Request withdrawn during the guard interval
        do_reset();
        step(3'b010, 3'b000);
        check("abort_change", int'(change), 1);
        step(3'b010, 3'b000);
        step(3'b000, 3'b000);
        check("abort_gnt", int'(gnt), 0);
        check("abort_sel", int'(sel_active), 1);
        step(3'b000, 3'b000);
        check("abort_park", int'(change), 3);
        check("abort_sel_park", int'(sel_active), 0);

`ifdef WATCHDOG_EN
        // Watchdog forced release
        do_reset();
        wait_grant(2, 3'b100, 3'b100);
        for (int i = 0; i < WDOG; i++) begin
            step(3'b101, 3'b100);
            check("wd_hold_trip", int'(wdog_trip), 0);
        end
        step(3'b101, 3'b100);
        check("wd_trip", int'(wdog_trip), 1);
        check("wd_gnt", int'(gnt), 0);
        check("wd_change", int'(change), 3);
        step(3'b101, 3'b100);
        check("wd_trip_pulse", int'(wdog_trip), 0);
        wait_grant(0, 3'b101, 3'b100);
`endif

        // Randomized traffic against the model
        do_reset();
        r = 3'b000;
        b = 3'b000;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(7) == 0) r[$urandom_range(2)] = ~r[$urandom_range(2)];
            if ($urandom_range(5) == 0) r[$urandom_range(2)] = 1'b0;
            if ($urandom_range(3) == 0) b = 3'($urandom_range(7));
            rst = ($urandom_range(299) == 0);
            step(r, b);
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
